fm_modulator: RTL and testbench
===============================

Name: fm_modulator

Overview:
- Digital FM transmitter: the counterpart of the fm receiver.
- Accepts 12-bit signed baseband audio samples and produces an 8-bit signed FM sample stream, one sample per clock, suitable for driving the receiver's fmin input directly.
- Built from a phase accumulator (NCO) with an audio-controlled increment, a quarter-wave sine LUT with quadrant folding, and a run/drain/idle control FSM that stops only at a phase wrap, so the carrier never switches off mid-cycle.

Parameters:
- PHASE_W, 24: phase accumulator width, bits.
- CARRIER_INC, 24'h400000: centre-frequency increment (default = fs/4).
- DEV_SHIFT, 8: left shift applied to sign-extended audio; sets peak deviation.
- AUDIO_W, 12: audio sample width, two's complement.
- OUT_W, 8: FM output width, two's complement.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  level; 1 requests modulation, 0 requests a stop at the next phase wrap.
- audio_in  input  AUDIO_W  signed audio sample.
- audio_valid  input  1  audio_in is valid this cycle.
- audio_ready  output  1  block accepts audio this cycle.
- fmout  output  OUT_W  signed FM sample.
- fm_valid  output  1  fmout carries a live sample.
- busy  output  1  FSM is not in IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - phase = 0, audio_reg = 0, FSM = IDLE.
  - All pipeline registers cleared.
  - fmout = 0, fm_valid = 0, busy = 0, audio_ready = 0.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE -> RUN when enable=1.
  - RUN -> DRAIN when enable=0.
  - DRAIN -> RUN when enable=1; the phase is not reset.
  - DRAIN -> IDLE on the cycle the accumulator carries out (phase + inc >= 2^PHASE_W). The phase register loads 0 on that edge.
  - In IDLE the phase is held at 0 and audio_reg is held.
- Handshake:
  - audio_ready = 1 exactly in RUN.
  - A transfer occurs on an edge where audio_valid & audio_ready = 1; audio_reg then loads audio_in.
  - audio_reg otherwise holds its value (zero-order hold); no back-pressure beyond the FSM state.
- Increment:
  - inc = CARRIER_INC + (sign_extend(audio_reg, PHASE_W) << DEV_SHIFT), truncated modulo 2^PHASE_W.
  - No saturation; wrap is intentional.
  - A newly accepted sample affects inc from the next cycle.
- Accumulator: in RUN and DRAIN, phase <= phase + inc (mod 2^PHASE_W) every cycle.
- Sine generation:
  - q = phase[PHASE_W-1:PHASE_W-2]; a = phase[PHASE_W-3:PHASE_W-10].
  - addr = a for q = 0 or 2; addr = ~a for q = 1 or 3.
  - LUT[k] = round(127 * sin(2*pi*(k+0.5)/1024)), k = 0..255, 7-bit magnitude.
  - Negate the magnitude for q = 2 or 3. -0 = 0; the output range is -127..+127 and -128 never occurs.
- Pipeline latency:
  - Stage 1 registers addr and the negate flag; stage 2 registers fmout.
  - fmout at edge n+2 reflects the phase present after edge n.
  - fm_valid is the state-is-RUN/DRAIN flag delayed by 2 cycles, aligned with fmout.
  - When the FSM reaches IDLE, fmout shows the last two in-flight samples and then 0, with fm_valid = 0 from the same point.
- busy = (state != IDLE), registered along with the state.
- Reset asserted mid-operation: immediate return to the reset values above; no drain.
- Simultaneous events:
  - In DRAIN, a carry-out on the same cycle as enable=1 goes to RUN and keeps the wrapped phase; it does not go to IDLE.
  - audio_valid while not in RUN is ignored.

Test Plan:
- Reset: drive reset=0 with random inputs -> fmout=0, fm_valid=0, busy=0, audio_ready=0; all stay so 5 cycles after release with enable=0.
- Carrier only: enable=1, audio_reg=0, default params -> after 2-cycle latency fmout repeats 0,+127,0,-127 with period 4, and fm_valid=1.
- Deviation: accept audio_in=12'h040 (DEV_SHIFT=8, inc=0x404000) -> phase increments by 0x404000 from the next cycle; fmout matches a reference NCO model bit-exactly over 1024 samples.
- Negative wrap: audio_in=12'h800 -> inc=0x400000-0x080000=0x380000 mod 2^24; period check matches the model; no output of -128.
- Drain: drop enable mid-cycle at phase 0x500000 -> audio_ready=0 at once; busy=1 until the carry-out; then phase=0, IDLE, fm_valid=0 two cycles later.
- Re-enable during DRAIN and async reset during RUN: -> DRAIN->RUN with phase continuous; the reset pulse clears all outputs within the same cycle, asynchronously, without waiting for clk.

Source files
------------

// File: rtl/fm_modulator_if.sv
// Audio-in / FM-out stream bundle for the FM modulator.
// The slave modport is the modulator side; the master modport is the source/sink side.
interface fm_modulator_if #(
    parameter int AUDIO_W = 12,
    parameter int OUT_W   = 8
);
    logic signed [AUDIO_W-1:0] audio_in;
    logic                      audio_valid;
    logic                      audio_ready;
    logic signed [OUT_W-1:0]   fmout;
    logic                      fm_valid;

    modport master (output audio_in, audio_valid, input audio_ready, fmout, fm_valid);
    modport slave  (input audio_in, audio_valid, output audio_ready, fmout, fm_valid);
endinterface

// File: rtl/fm_modulator.sv
// FM modulator: an audio-steered NCO feeds a quarter-wave sine LUT through a 2-stage pipeline.
// The run/drain/idle FSM stops only at a phase wrap, so the carrier never ends mid-cycle.
module fm_modulator #(
    parameter int                 PHASE_W     = 24,
    parameter logic [PHASE_W-1:0] CARRIER_INC = 24'h400000,
    parameter int                 DEV_SHIFT   = 8,
    parameter int                 AUDIO_W     = 12,
    parameter int                 OUT_W       = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    output logic          busy,
    fm_modulator_if.slave bus
);
    localparam int   STAGES = 2;
    localparam real  PI     = 3.14159265358979323846;

    // Taylor series keeps the table build free of math-library calls at elaboration.
    function automatic real sin_taylor(input real x);
        real term;
        real acc;
        term = x;
        acc  = x;
        for (int n = 1; n < 14; n++) begin
            term = -term * x * x / ((2.0 * n) * (2.0 * n + 1.0));
            acc  = acc + term;
        end
        return acc;
    endfunction

    function automatic logic [256*7-1:0] build_lut();
        logic [256*7-1:0] lut;
        real              v;
        lut = '0;
        for (int k = 0; k < 256; k++) begin
            v = 127.0 * sin_taylor(2.0 * PI * (k + 0.5) / 1024.0);
            lut[k*7 +: 7] = 7'($rtoi(v + 0.5));
        end
        return lut;
    endfunction

    localparam logic [256*7-1:0] LUT = build_lut();

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                    state, state_nxt;
    logic [PHASE_W-1:0]        phase, phase_nxt, inc;
    logic [PHASE_W:0]          sum;
    logic signed [AUDIO_W-1:0] audio_reg;
    logic [STAGES:0]           vld_pipe;
    logic [7:0]                addr_q;
    logic                      neg_q;
    logic [1:0]                quad;
    logic [7:0]                frac;
    logic [6:0]                mag;
    logic signed [OUT_W-1:0]   mag_ext;

    // Deviation wraps modulo 2^PHASE_W on purpose; no saturation.
    assign inc = CARRIER_INC
               + ({{(PHASE_W-AUDIO_W){audio_reg[AUDIO_W-1]}}, audio_reg} << DEV_SHIFT);
    assign sum = {1'b0, phase} + {1'b0, inc};

    always_comb begin
        state_nxt = state;
        phase_nxt = phase;
        case (state)
            IDLE: begin
                phase_nxt = '0;
                if (enable) state_nxt = RUN;
            end
            RUN: begin
                phase_nxt = sum[PHASE_W-1:0];
                if (!enable) state_nxt = DRAIN;
            end
            DRAIN: begin
                phase_nxt = sum[PHASE_W-1:0];
                // Re-enable beats a simultaneous carry-out and keeps the wrapped phase.
                if (enable) begin
                    state_nxt = RUN;
                end else if (sum[PHASE_W]) begin
                    state_nxt = IDLE;
                    phase_nxt = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                phase_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            phase     <= '0;
            audio_reg <= '0;
            vld_pipe  <= '0;
        end else begin
            state    <= state_nxt;
            phase    <= phase_nxt;
            vld_pipe <= {vld_pipe[STAGES-1:0], state_nxt != IDLE};
            if (state == RUN && bus.audio_valid) audio_reg <= bus.audio_in;
        end
    end

    assign busy            = vld_pipe[0];
    assign bus.audio_ready = (state == RUN);
    assign bus.fm_valid    = vld_pipe[STAGES];

    assign quad    = phase[PHASE_W-1 -: 2];
    assign frac    = phase[PHASE_W-3 -: 8];
    assign mag     = LUT[int'(addr_q)*7 +: 7];
    assign mag_ext = OUT_W'(mag);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q    <= '0;
            neg_q     <= 1'b0;
            bus.fmout <= '0;
        end else begin
            // Odd quadrants read the table mirrored; the lower half-cycle is negated.
            addr_q    <= quad[0] ? ~frac : frac;
            neg_q     <= quad[1];
            bus.fmout <= neg_q ? -mag_ext : mag_ext;
        end
    end
endmodule

// File: tb/tb_fm_modulator.sv
// Scoreboard bench for fm_modulator: a cycle model built from plain phase arithmetic and $sin
// pushes expected samples; a negedge monitor pops and compares against the DUT stream.
module tb_fm_modulator;
    localparam longint M  = 64'sh1000000;
    localparam real    PI = 3.141592653589793;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic enable = 1'b0;
    logic busy;

    fm_modulator_if bus ();

    fm_modulator dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .busy   (busy),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int fm;
        bit vld;
    } exp_t;

    exp_t   exq[$];
    int     n_pass = 0;
    int     n_chk  = 0;
    bit     model_on = 1'b0;
    bit     chk_en   = 1'b0;
    int     mode     = 0;      // 0 idle, 1 modulating, 2 finishing the carrier cycle
    longint m_phase  = 0;
    int     m_areg   = 0;

    // Full-circle sine at the centre of the 1/1024 phase bin, rounded half away from zero.
    function automatic int ref_sample(input longint p);
        real v;
        real m;
        int  mag;
        v   = 127.0 * $sin(2.0 * PI * (real'(p >>> 14) + 0.5) / 1024.0);
        m   = (v < 0.0) ? -v : v;
        mag = $rtoi(m + 0.5);
        return (v < 0.0) ? -mag : mag;
    endfunction

    function automatic longint ref_inc(input int a);
        longint t;
        t = 64'sh400000 + longint'(a) * 256;
        return ((t % M) + M) % M;
    endfunction

    always @(posedge clk) begin
        longint s;
        int     nm;
        exp_t   e;
        if (model_on) begin
            s  = m_phase + ref_inc(m_areg);
            nm = mode;
            case (mode)
                0: if (enable) nm = 1;
                1: begin
                    if (bus.audio_valid) m_areg = int'($signed(bus.audio_in));
                    m_phase = s % M;
                    if (!enable) nm = 2;
                end
                default: begin
                    if (enable) begin
                        nm = 1;
                        m_phase = s % M;
                    end else if (s >= M) begin
                        nm = 0;
                        m_phase = 0;
                    end else begin
                        m_phase = s;
                    end
                end
            endcase
            mode  = nm;
            e.fm  = ref_sample(m_phase);
            e.vld = (mode != 0);
            exq.push_back(e);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        int   got;
        if (chk_en) begin
            got = int'($signed(bus.fmout));
            n_chk++;
            if (exq.size() == 0) begin
                $display("FAIL scoreboard_empty t=%0t fmout=%0d", $time, got);
            end else begin
                e = exq.pop_front();
                if (got !== e.fm || bus.fm_valid !== e.vld || busy !== (mode != 0) ||
                    bus.audio_ready !== (mode == 1) || got == -128)
                    $display("FAIL stream t=%0t got fmout=%0d fm_valid=%b busy=%b ready=%b want fmout=%0d fm_valid=%b busy=%b ready=%b",
                             $time, got, bus.fm_valid, busy, bus.audio_ready,
                             e.fm, e.vld, (mode != 0), (mode == 1));
                else
                    n_pass++;
            end
        end
    end

    task automatic check_idle(input string name);
        n_chk++;
        if (bus.fmout === '0 && bus.fm_valid === 1'b0 && busy === 1'b0 && bus.audio_ready === 1'b0)
            n_pass++;
        else
            $display("FAIL %s t=%0t got fmout=%0d fm_valid=%b busy=%b audio_ready=%b want all 0",
                     name, $time, $signed(bus.fmout), bus.fm_valid, busy, bus.audio_ready);
    endtask

    task automatic release_reset();
        exp_t z;
        z.fm  = 0;
        z.vld = 1'b0;
        @(negedge clk);
        mode    = 0;
        m_phase = 0;
        m_areg  = 0;
        exq.delete();
        exq.push_back(z);
        exq.push_back(z);
        reset    = 1'b1;
        model_on = 1'b1;
        @(posedge clk);
        #1 chk_en = 1'b1;
    endtask

    task automatic send_audio(input logic [11:0] s);
        @(negedge clk);
        bus.audio_in    = s;
        bus.audio_valid = 1'b1;
        @(negedge clk);
        bus.audio_valid = 1'b0;
    endtask

    task automatic random_run(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if ($urandom_range(15) == 0) enable = ~enable;
            bus.audio_valid = ($urandom_range(2) == 0);
            bus.audio_in    = 12'($urandom);
        end
    endtask

    task automatic drain_to_idle(input string name);
        bit done;
        done = 1'b0;
        @(negedge clk);
        enable = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            #1 if (!busy) done = 1'b1;
        end
        n_chk++;
        if (done) n_pass++;
        else $display("FAIL %s_timeout busy=%b want 0 within 200 cycles", name, busy);
    endtask

    initial begin
        int  pat[4];
        bit  seen;
        pat = '{0, 127, 0, -127};
        bus.audio_in    = '0;
        bus.audio_valid = 1'b0;

        // Reset held with random inputs.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            enable          = 1'($urandom);
            bus.audio_valid = 1'($urandom);
            bus.audio_in    = 12'($urandom);
            #1 check_idle("reset_hold");
        end
        enable          = 1'b0;
        bus.audio_valid = 1'b0;
        release_reset();
        repeat (5) @(negedge clk);

        // Carrier only: 0,+127,0,-127 once valid.
        enable = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(posedge clk);
            #1 if (bus.fm_valid) seen = 1'b1;
        end
        n_chk++;
        if (seen) n_pass++;
        else $display("FAIL carrier_valid_timeout fm_valid=%b want 1", bus.fm_valid);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            n_chk++;
            if ($signed(bus.fmout) == pat[i % 4]) n_pass++;
            else $display("FAIL carrier_pattern idx=%0d got %0d want %0d", i, $signed(bus.fmout), pat[i % 4]);
        end

        send_audio(12'h040);
        repeat (1024) @(negedge clk);
        send_audio(12'h800);
        repeat (600) @(negedge clk);
        drain_to_idle("drain_neg");
        repeat (4) @(negedge clk);

        // Re-enable one cycle after dropping enable: DRAIN back to RUN with phase kept.
        enable = 1'b1;
        send_audio(12'h123);
        repeat (7) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        repeat (20) @(negedge clk);

        random_run(3000);

        // Asynchronous reset in the middle of a clock period while running.
        @(negedge clk);
        enable = 1'b1;
        repeat (10) @(negedge clk);
        @(posedge clk);
        #3 reset = 1'b0;
        chk_en   = 1'b0;
        model_on = 1'b0;
        #1 check_idle("async_reset");
        repeat (3) @(negedge clk);
        #1 check_idle("async_reset_hold");
        enable = 1'b1;
        release_reset();
        random_run(300);
        drain_to_idle("drain_final");
        repeat (4) @(negedge clk);
        #1 chk_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
